// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use bubble insertion and a saturating bubble counter.
// Define LOAD_USE_DETECT_EN to enable load-use detection; otherwise bubbles come only from flush.
module id_ex_stage #(
    parameter int WIDTH   = 32,
    parameter int ALUOP_W = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall_in,
    input  logic               flush,
    input  logic [WIDTH-1:0]   id_pc4,
    input  logic [WIDTH-1:0]   id_data1,
    input  logic [WIDTH-1:0]   id_data2,
    input  logic [WIDTH-1:0]   id_imm,
    input  logic [4:0]         id_rs,
    input  logic [4:0]         id_rt,
    input  logic [4:0]         id_rd,
    input  logic               id_reg_write,
    input  logic               id_mem_read,
    input  logic               id_mem_write,
    input  logic               id_mem_to_reg,
    input  logic               id_alu_src,
    input  logic               id_reg_dst,
    input  logic [ALUOP_W-1:0] id_alu_op,
    input  logic               id_valid,
    output logic [WIDTH-1:0]   ex_pc4,
    output logic [WIDTH-1:0]   ex_data1,
    output logic [WIDTH-1:0]   ex_data2,
    output logic [WIDTH-1:0]   ex_imm,
    output logic [4:0]         ex_rs,
    output logic [4:0]         ex_rt,
    output logic [4:0]         ex_rd,
    output logic               ex_reg_write,
    output logic               ex_mem_read,
    output logic               ex_mem_write,
    output logic               ex_mem_to_reg,
    output logic               ex_alu_src,
    output logic               ex_reg_dst,
    output logic [ALUOP_W-1:0] ex_alu_op,
    output logic               ex_valid,
    output logic               hazard_stall,
    output logic [15:0]        bubble_cnt
);
    logic bubble;

`ifdef LOAD_USE_DETECT_EN
    // flush suppresses the stall so upstream is not held for an instruction being squashed
    assign hazard_stall = ex_valid & ex_mem_read & (ex_rt != 5'd0) &
                          ((ex_rt == id_rs) | (ex_rt == id_rt)) & id_valid & ~flush;
`else
    assign hazard_stall = 1'b0;
`endif

    assign bubble = flush | hazard_stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_pc4        <= '0;
            ex_data1      <= '0;
            ex_data2      <= '0;
            ex_imm        <= '0;
            ex_rs         <= '0;
            ex_rt         <= '0;
            ex_rd         <= '0;
            ex_reg_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_mem_to_reg <= 1'b0;
            ex_alu_src    <= 1'b0;
            ex_reg_dst    <= 1'b0;
            ex_alu_op     <= '0;
            ex_valid      <= 1'b0;
            bubble_cnt    <= '0;
        end else if (!stall_in) begin
            ex_pc4        <= bubble ? '0 : id_pc4;
            ex_data1      <= bubble ? '0 : id_data1;
            ex_data2      <= bubble ? '0 : id_data2;
            ex_imm        <= bubble ? '0 : id_imm;
            ex_rs         <= bubble ? '0 : id_rs;
            ex_rt         <= bubble ? '0 : id_rt;
            ex_rd         <= bubble ? '0 : id_rd;
            ex_reg_write  <= ~bubble & id_reg_write;
            ex_mem_read   <= ~bubble & id_mem_read;
            ex_mem_write  <= ~bubble & id_mem_write;
            ex_mem_to_reg <= ~bubble & id_mem_to_reg;
            ex_alu_src    <= ~bubble & id_alu_src;
            ex_reg_dst    <= ~bubble & id_reg_dst;
            ex_alu_op     <= bubble ? '0 : id_alu_op;
            ex_valid      <= ~bubble & id_valid;
            if (bubble && bubble_cnt != 16'hFFFF)
                bubble_cnt <= bubble_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed plus randomized checks of id_ex_stage against a field-level reference model.
module tb_id_ex_stage;
    typedef struct packed {
        logic [31:0] pc4, d1, d2, imm;
        logic [4:0]  rs, rt, rd;
        logic        rw, mr, mw, m2r, as, rdst;
        logic [2:0]  op;
        logic        v;
    } f_t;

    logic clk = 1'b0, rst = 1'b1, stall_in = 1'b0, flush = 1'b0;
    logic [31:0] id_pc4 = '0, id_data1 = '0, id_data2 = '0, id_imm = '0;
    logic [4:0]  id_rs = '0, id_rt = '0, id_rd = '0;
    logic id_reg_write = 0, id_mem_read = 0, id_mem_write = 0, id_mem_to_reg = 0, id_alu_src = 0, id_reg_dst = 0;
    logic [2:0]  id_alu_op = '0;
    logic        id_valid = 1'b0;
    logic [31:0] ex_pc4, ex_data1, ex_data2, ex_imm;
    logic [4:0]  ex_rs, ex_rt, ex_rd;
    logic ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_reg_dst;
    logic [2:0]  ex_alu_op;
    logic        ex_valid, hazard_stall;
    logic [15:0] bubble_cnt;

    f_t m;
    int cnt = 0, compared = 0, mismatched = 0;

    id_ex_stage #(.WIDTH(32), .ALUOP_W(3)) dut (
        .clk(clk), .rst(rst), .stall_in(stall_in), .flush(flush),
        .id_pc4(id_pc4), .id_data1(id_data1), .id_data2(id_data2), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_mem_to_reg(id_mem_to_reg), .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst),
        .id_alu_op(id_alu_op), .id_valid(id_valid),
        .ex_pc4(ex_pc4), .ex_data1(ex_data1), .ex_data2(ex_data2), .ex_imm(ex_imm),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_alu_src(ex_alu_src), .ex_reg_dst(ex_reg_dst),
        .ex_alu_op(ex_alu_op), .ex_valid(ex_valid),
        .hazard_stall(hazard_stall), .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    function automatic f_t id_f();
        return {id_pc4, id_data1, id_data2, id_imm, id_rs, id_rt, id_rd, id_reg_write, id_mem_read,
                id_mem_write, id_mem_to_reg, id_alu_src, id_reg_dst, id_alu_op, id_valid};
    endfunction

    function automatic f_t ex_f();
        return {ex_pc4, ex_data1, ex_data2, ex_imm, ex_rs, ex_rt, ex_rd, ex_reg_write, ex_mem_read,
                ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_reg_dst, ex_alu_op, ex_valid};
    endfunction

    // a load in EX whose destination a valid ID instruction reads, unless flushed
    function automatic logic exp_hz();
`ifdef LOAD_USE_DETECT_EN
        return m.v && m.mr && m.rt != 5'd0 && (m.rt == id_rs || m.rt == id_rt) && id_valid && !flush;
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] want);
        compared++;
        assert (got === want) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic chk_state(input string tag);
        chk({tag, ".ex"}, 256'(ex_f()), 256'(m));
        chk({tag, ".cnt"}, 256'(bubble_cnt), 256'(cnt));
    endtask

    // inputs are set by the caller just after a falling edge
    task automatic cycle(input string tag, input bit check = 1'b1);
        f_t nx;
        logic hz;
        #1;
        hz = exp_hz();
        if (check) chk({tag, ".hz"}, 256'(hazard_stall), 256'(hz));
        nx = stall_in ? m : (flush || hz) ? '0 : id_f();
        @(posedge clk);
        if (!stall_in && (flush || hz) && cnt < 65535) cnt++;
        m = nx;
        @(negedge clk);
        if (check) chk_state(tag);
    endtask

    task automatic set_id(input logic [4:0] rs, input logic [4:0] rt, input logic mr, input logic v);
        id_pc4 = $urandom; id_data1 = $urandom; id_data2 = $urandom; id_imm = $urandom;
        id_rs = rs; id_rt = rt; id_rd = 5'($urandom);
        {id_reg_write, id_mem_write, id_mem_to_reg, id_alu_src, id_reg_dst} = 5'($urandom);
        id_alu_op = 3'($urandom); id_mem_read = mr; id_valid = v;
    endtask

    initial begin
        m = '0;
        #3;
        chk_state("reset");
        chk("reset.hz", 256'(hazard_stall), 256'(0));
        @(negedge clk);
        rst = 1'b0;

        set_id(5'd5, 5'd6, 1'b0, 1'b1);
        id_data1 = 32'hDEADBEEF; id_reg_write = 1'b1;
        cycle("pass");
        chk("pass.data1", 256'(ex_data1), 256'(32'hDEADBEEF));
        chk("pass.rs", 256'(ex_rs), 256'(5));
        chk("pass.rw", 256'(ex_reg_write), 256'(1));

        set_id(5'd1, 5'd8, 1'b1, 1'b1);
        cycle("lw8");
        set_id(5'd8, 5'd2, 1'b0, 1'b1);
        #1;
`ifdef LOAD_USE_DETECT_EN
        chk("lu.hz_on", 256'(hazard_stall), 256'(1));
`endif
        cycle("lu.bubble");
        cycle("lu.dep");
        chk("lu.dep_rs", 256'(ex_rs), 256'(8));
        chk("lu.hz_off", 256'(hazard_stall), 256'(0));

        set_id(5'd3, 5'd0, 1'b1, 1'b1);
        cycle("lw0");
        set_id(5'd0, 5'd0, 1'b0, 1'b1);
        cycle("lw0.dep");
        chk("lw0.novalid_bubble", 256'(ex_valid), 256'(1));

        set_id(5'd4, 5'd9, 1'b1, 1'b1);
        cycle("lw9");
        set_id(5'd9, 5'd1, 1'b0, 1'b1);
        flush = 1'b1;
        cycle("flush_hz");
        flush = 1'b0;
        set_id(5'd7, 5'd7, 1'b0, 1'b1);
        cycle("after_flush");

        set_id(5'd2, 5'd3, 1'b1, 1'b1);
        cycle("pre_freeze");
        stall_in = 1'b1; flush = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_id(5'($urandom), 5'($urandom), 1'b1, 1'b1);
            cycle("freeze");
        end
        stall_in = 1'b0; flush = 1'b0;

        set_id(5'd1, 5'd2, 1'b0, 1'b1);
        id_reg_write = 1'b1;
        cycle("pre_rst");
        #2;
        rst = 1'b1;
        m = '0; cnt = 0;
        #1;
        chk_state("async_rst");
        chk("async_rst.hz", 256'(hazard_stall), 256'(0));
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 400; i++) begin
            set_id(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom), $urandom_range(0, 9) != 0);
            flush = $urandom_range(0, 7) == 0;
            stall_in = $urandom_range(0, 7) == 0;
            cycle("rand");
        end
        stall_in = 1'b0;

        flush = 1'b1;
        while (cnt < 65535) cycle("sat_fill", 1'b0);
        chk_state("sat_full");
        cycle("sat_hold");
        chk("sat.cnt", 256'(bubble_cnt), 256'(16'hFFFF));
        flush = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
